// File: rtl/miner_pkg.sv
// Shared types and widths for the mining job controller.
// Status codes travel to the host alongside the result.
package miner_pkg;

  localparam int BLOCK_W = 608;
  localparam int HASH_W  = 256;

  typedef enum logic [1:0] {
    ST_FOUND     = 2'd0,
    ST_EXHAUSTED = 2'd1,
    ST_TIMEOUT   = 2'd2,
    ST_ABORTED   = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_REPORT
  } state_t;

endpackage

// File: rtl/miner_job_counter.sv
// Loadable nonce counter with inclusive end detect.
// at_end is checked before increment so the range never wraps.
module miner_job_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_value,
  input  logic [W-1:0] end_value,
  output logic [W-1:0] value,
  output logic         at_end
);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

  assign at_end = (value == end_value);

endmodule

// File: rtl/miner_job_ctrl.sv
// Walks one job's nonce range through the hash core and
// reports FOUND/EXHAUSTED/TIMEOUT/ABORTED via a held result.
module miner_job_ctrl
  import miner_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int NONCE_W        = 32
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [BLOCK_W-1:0] job_block,
  input  logic [HASH_W-1:0]  job_target,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [NONCE_W-1:0] job_nonce_end,
  input  logic               abort,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_block,
  output logic [NONCE_W-1:0] core_nonce,
  input  logic               core_done,
  input  logic [HASH_W-1:0]  core_hash,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [1:0]         res_status,
  output logic [HASH_W-1:0]  res_hash,
  output logic [NONCE_W-1:0] res_nonce,
  output logic [31:0]        res_attempts
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [BLOCK_W-1:0]   block_q;
  logic [HASH_W-1:0]    target_q;
  logic [HASH_W-1:0]    hash_q;
  logic [NONCE_W-1:0]   end_q;
  logic [TO_W-1:0]      tmo_q;
  logic [31:0]          attempts_q;
  status_t              res_status_q;
  logic [HASH_W-1:0]    res_hash_q;
  logic [NONCE_W-1:0]   res_nonce_q;

  logic                 latch_job;
  logic                 cnt_load;
  logic                 cnt_inc;
  logic                 tmo_clr;
  logic                 tmo_inc;
  logic                 cap_hash;
  logic                 set_res;
  status_t              status_d;
  logic [NONCE_W-1:0]   nonce_d;
  logic [HASH_W-1:0]    hash_d;
  logic [NONCE_W-1:0]   cur_nonce;
  logic                 at_end;
  logic                 busy;

  miner_job_counter #(
    .W (NONCE_W)
  ) u_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (cnt_load),
    .inc        (cnt_inc),
    .load_value (job_nonce_start),
    .end_value  (end_q),
    .value      (cur_nonce),
    .at_end     (at_end)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q == S_ISSUE) ||
                (state_q == S_WAIT)  ||
                (state_q == S_CHECK);

  always_comb begin
    state_d   = state_q;
    latch_job = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    cap_hash  = 1'b0;
    set_res   = 1'b0;
    status_d  = ST_FOUND;
    nonce_d   = '0;
    hash_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          latch_job = 1'b1;
          if (job_nonce_end < job_nonce_start) begin
            set_res  = 1'b1;
            status_d = ST_EXHAUSTED;
            nonce_d  = job_nonce_start;
            state_d  = S_REPORT;
          end else begin
            cnt_load = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmo_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cap_hash = core_done;
        if (core_done) begin
          state_d = S_CHECK;
        end else if (tmo_q == TO_MAX) begin
          set_res  = 1'b1;
          status_d = ST_TIMEOUT;
          nonce_d  = cur_nonce;
          state_d  = S_REPORT;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_CHECK: begin
        if (hash_q <= target_q) begin
          set_res  = 1'b1;
          status_d = ST_FOUND;
          nonce_d  = cur_nonce;
          hash_d   = hash_q;
          state_d  = S_REPORT;
        end else if (at_end) begin
          set_res  = 1'b1;
          status_d = ST_EXHAUSTED;
          nonce_d  = end_q;
          state_d  = S_REPORT;
        end else begin
          cnt_inc = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_REPORT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort wins over every busy-state transition; a same-cycle
    // core_done still counts as a completed attempt
    if (busy && abort) begin
      cnt_inc  = 1'b0;
      tmo_clr  = 1'b0;
      tmo_inc  = 1'b0;
      set_res  = 1'b1;
      status_d = ST_ABORTED;
      nonce_d  = cur_nonce;
      hash_d   = '0;
      state_d  = S_REPORT;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      block_q      <= '0;
      target_q     <= '0;
      end_q        <= '0;
      hash_q       <= '0;
      tmo_q        <= '0;
      attempts_q   <= '0;
      res_status_q <= ST_FOUND;
      res_hash_q   <= '0;
      res_nonce_q  <= '0;
    end else begin
      if (latch_job) begin
        block_q    <= job_block;
        target_q   <= job_target;
        end_q      <= job_nonce_end;
        attempts_q <= '0;
      end
      if (tmo_clr) begin
        tmo_q <= '0;
      end else if (tmo_inc) begin
        tmo_q <= tmo_q + TO_W'(1);
      end
      if (cap_hash) begin
        hash_q     <= core_hash;
        attempts_q <= attempts_q + 32'd1;
      end
      if (set_res) begin
        res_status_q <= status_d;
        res_nonce_q  <= nonce_d;
        res_hash_q   <= hash_d;
      end
    end
  end

  assign job_ready    = n_rst && (state_q == S_IDLE);
  assign core_start   = (state_q == S_ISSUE);
  assign core_block   = block_q;
  assign core_nonce   = cur_nonce;
  assign res_valid    = (state_q == S_REPORT);
  assign res_status   = res_status_q;
  assign res_hash     = res_hash_q;
  assign res_nonce    = res_nonce_q;
  assign res_attempts = attempts_q;

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Directed bench for miner_job_ctrl with a small hash core model.
// Core answers on the 5th rising edge after the start cycle.
module tb_miner_job_ctrl;
  import miner_pkg::*;

  localparam int TO = 16;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               job_valid;
  logic               job_ready;
  logic [BLOCK_W-1:0] job_block;
  logic [HASH_W-1:0]  job_target;
  logic [31:0]        job_nonce_start;
  logic [31:0]        job_nonce_end;
  logic               abort;
  logic               core_start;
  logic [BLOCK_W-1:0] core_block;
  logic [31:0]        core_nonce;
  logic               core_done;
  logic [HASH_W-1:0]  core_hash;
  logic               res_valid;
  logic               res_ready;
  logic [1:0]         res_status;
  logic [HASH_W-1:0]  res_hash;
  logic [31:0]        res_nonce;
  logic [31:0]        res_attempts;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_starts = 0;
  logic [31:0] st_nonce [64];
  int          st_cyc   [64];

  bit          core_en = 1'b1;
  bit          hit_en = 1'b0;
  logic [31:0] hit_nonce = '0;
  logic [HASH_W-1:0] hit_hash = '0;
  logic [HASH_W-1:0] miss_hash = '0;

  logic [BLOCK_W-1:0] blk;

  miner_job_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .NONCE_W        (32)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_block       (job_block),
    .job_target      (job_target),
    .job_nonce_start (job_nonce_start),
    .job_nonce_end   (job_nonce_end),
    .abort           (abort),
    .core_start      (core_start),
    .core_block      (core_block),
    .core_nonce      (core_nonce),
    .core_done       (core_done),
    .core_hash       (core_hash),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_status      (res_status),
    .res_hash        (res_hash),
    .res_nonce       (res_nonce),
    .res_attempts    (res_attempts)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (core_start === 1'b1) begin
      if (n_starts < 64) begin
        st_nonce[n_starts] = core_nonce;
        st_cyc[n_starts]   = cyc;
      end
      n_starts = n_starts + 1;
    end
  end

  initial begin
    logic [31:0] n;
    core_done = 1'b0;
    core_hash = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1 && core_en) begin
        n = core_nonce;
        repeat (5) @(posedge clk);
        #1;
        core_done = 1'b1;
        core_hash = (hit_en && n == hit_nonce) ? hit_hash : miss_hash;
        @(posedge clk);
        #1;
        core_done = 1'b0;
        core_hash = '0;
      end
    end
  end

  task automatic offer_job(input logic [HASH_W-1:0] tgt,
                           input logic [31:0] s, input logic [31:0] e);
    @(posedge clk);
    #1;
    job_block       = blk;
    job_target      = tgt;
    job_nonce_start = s;
    job_nonce_end   = e;
    job_valid       = 1'b1;
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL job_ready_idle got=%b want=1", job_ready);
    end
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_result(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL res_valid_timeout got=0 want=1");
    end
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b0 || core_start !== 1'b0 || res_valid !== 1'b0 ||
        core_nonce !== '0 || res_attempts !== '0 || res_hash !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b %0h %0h want=000 0 0",
               job_ready, core_start, res_valid, core_nonce, res_attempts);
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b want=1", job_ready);
    end
  endtask

  task automatic test_found();
    bit seen;
    int base;
    core_en = 1'b1; hit_en = 1'b0;
    miss_hash = 256'h1234_5678_9abc;
    base = n_starts;
    offer_job('1, 32'd5, 32'd9);
    wait_result(seen);
    checks++;
    if (res_status !== ST_FOUND || res_nonce !== 32'd5 ||
        res_attempts !== 32'd1 || res_hash !== miss_hash) begin
      errors++;
      $display("FAIL found got=%0d %0h %0d %0h want=0 5 1 %0h",
               res_status, res_nonce, res_attempts, res_hash, miss_hash);
    end
    take_result();
    repeat (10) @(negedge clk);
    checks++;
    if (n_starts - base != 1) begin
      errors++;
      $display("FAIL found_starts got=%0d want=1", n_starts - base);
    end
  endtask

  task automatic test_exhaust();
    bit seen;
    int base;
    hit_en = 1'b0;
    miss_hash = 256'h1;
    base = n_starts;
    offer_job('0, 32'd10, 32'd12);
    wait_result(seen);
    checks++;
    if (res_status !== ST_EXHAUSTED || res_nonce !== 32'd12 ||
        res_attempts !== 32'd3 || res_hash !== '0) begin
      errors++;
      $display("FAIL exhaust got=%0d %0h %0d want=1 c 3",
               res_status, res_nonce, res_attempts);
    end
    checks++;
    if (n_starts - base != 3) begin
      errors++;
      $display("FAIL exhaust_starts got=%0d want=3", n_starts - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (st_nonce[base+k] !== 32'd10 + 32'(k)) begin
          errors++;
          $display("FAIL exhaust_nonce%0d got=%0d want=%0d",
                   k, st_nonce[base+k], 10 + k);
        end
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (st_cyc[base+k] - st_cyc[base+k-1] != 7) begin
          errors++;
          $display("FAIL exhaust_spacing%0d got=%0d want=7",
                   k, st_cyc[base+k] - st_cyc[base+k-1]);
        end
      end
    end
    take_result();
  endtask

  task automatic test_range_edges();
    bit seen;
    int base;
    miss_hash = 256'h5;
    base = n_starts;
    offer_job('0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    wait_result(seen);
    checks++;
    if (res_status !== ST_EXHAUSTED || res_nonce !== 32'hFFFF_FFFF ||
        res_attempts !== 32'd2) begin
      errors++;
      $display("FAIL top_range got=%0d %0h %0d want=1 ffffffff 2",
               res_status, res_nonce, res_attempts);
    end
    take_result();
    repeat (10) @(negedge clk);
    checks++;
    if (n_starts - base != 2) begin
      errors++;
      $display("FAIL top_range_starts got=%0d want=2", n_starts - base);
    end
    base = n_starts;
    offer_job('1, 32'd7, 32'd6);
    wait_result(seen);
    checks++;
    if (res_status !== ST_EXHAUSTED || res_nonce !== 32'd7 ||
        res_attempts !== 32'd0 || n_starts != base) begin
      errors++;
      $display("FAIL empty_range got=%0d %0h %0d starts=%0d want=1 7 0 0",
               res_status, res_nonce, res_attempts, n_starts - base);
    end
    take_result();
  endtask

  task automatic test_equal_target();
    bit seen;
    logic [HASH_W-1:0] t;
    t = {32'h0000_0001, 224'h0};
    miss_hash = t + 256'd1;
    hit_en = 1'b1; hit_nonce = 32'd3; hit_hash = t;
    offer_job(t, 32'd0, 32'd8);
    wait_result(seen);
    checks++;
    if (res_status !== ST_FOUND || res_nonce !== 32'd3 ||
        res_hash !== t || res_attempts !== 32'd4) begin
      errors++;
      $display("FAIL equal_target got=%0d %0h %0h %0d want=0 3 %0h 4",
               res_status, res_nonce, res_hash, res_attempts, t);
    end
    take_result();
    hit_en = 1'b0;
  endtask

  task automatic test_timeout();
    bit seen;
    int base;
    core_en = 1'b0;
    base = n_starts;
    offer_job('0, 32'd100, 32'd200);
    wait_result(seen);
    checks++;
    if (res_status !== ST_TIMEOUT || res_nonce !== 32'd100 ||
        res_attempts !== 32'd0 || res_hash !== '0) begin
      errors++;
      $display("FAIL timeout got=%0d %0d %0d want=2 100 0",
               res_status, res_nonce, res_attempts);
    end
    checks++;
    if (n_starts - base != 1 || cyc - st_cyc[base] != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency got=%0d want=%0d",
               cyc - st_cyc[base], TO + 1);
    end
    take_result();
    core_en = 1'b1;
  endtask

  task automatic test_abort_with_done();
    bit seen;
    bit got;
    core_en = 1'b1;
    miss_hash = 256'h9;
    offer_job('0, 32'd20, 32'd30);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (core_start === 1'b1) got = 1'b1;
    end
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_result(seen);
    checks++;
    if (res_status !== ST_ABORTED || res_nonce !== 32'd20 ||
        res_attempts !== 32'd1 || res_hash !== '0) begin
      errors++;
      $display("FAIL abort_done got=%0d %0d %0d want=3 20 1",
               res_status, res_nonce, res_attempts);
    end
    take_result();
  endtask

  task automatic test_hold_result();
    bit seen;
    logic [HASH_W-1:0] h;
    h = 256'hCAFE_F00D_0000_0001;
    miss_hash = h;
    offer_job('1, 32'd40, 32'd50);
    wait_result(seen);
    job_block = ~blk; job_target = '0;
    job_nonce_start = 32'd1; job_nonce_end = 32'd2;
    job_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || job_ready !== 1'b0 || core_start !== 1'b0 ||
          res_status !== ST_FOUND || res_nonce !== 32'd40 ||
          res_hash !== h || res_attempts !== 32'd1) begin
        errors++;
        $display("FAIL hold_cycle%0d got=%b%b %0d %0d %0d want=10 0 40 1",
                 i, res_valid, job_ready, res_status, res_nonce, res_attempts);
      end
    end
    job_valid = 1'b0;
    take_result();
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got=%b%b want=10", job_ready, res_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    bit got;
    offer_job('0, 32'd0, 32'd5);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (core_start === 1'b1) got = 1'b1;
    end
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b0 || core_start !== 1'b0 || res_valid !== 1'b0 ||
        core_block !== '0 || core_nonce !== '0 || res_status !== 2'd0 ||
        res_hash !== '0 || res_nonce !== '0 || res_attempts !== '0) begin
      errors++;
      $display("FAIL reset_wait got=%b%b%b nonce=%0h att=%0d want=000 0 0",
               job_ready, core_start, res_valid, core_nonce, res_attempts);
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_ready got=%b want=1", job_ready);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_noreport got=%b%b want=01", res_valid, job_ready);
    end
  endtask

  initial begin
    blk             = {19{32'hDEAD_BEEF}};
    n_rst           = 1'b0;
    job_valid       = 1'b0;
    job_block       = '0;
    job_target      = '0;
    job_nonce_start = '0;
    job_nonce_end   = '0;
    abort           = 1'b0;
    res_ready       = 1'b0;
    test_reset();
    test_found();
    test_exhaust();
    test_range_edges();
    test_equal_target();
    test_timeout();
    test_abort_with_done();
    test_hold_result();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
